// File: rtl/iiitb_rv32i_trace_cap.sv
// Writeback trace capture: records {NPC, WB_OUT} on every NPC change into a FWFT FIFO.
// Optional per-record cycle timestamp when TRACE_TIMESTAMP_EN is defined.
module iiitb_rv32i_trace_cap #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     RN,
  input  logic [31:0]              NPC,
  input  logic [31:0]              WB_OUT,
  input  logic                     cap_en,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [31:0]              rec_npc,
  output logic [31:0]              rec_wb,
  output logic [TS_W-1:0]          rec_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic [15:0]              drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [31:0]      prev_npc_q, prev_npc_d;
  logic             prev_vld_q, prev_vld_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [31:0]      npc_mem_q [DEPTH];
  logic [31:0]      npc_mem_d [DEPTH];
  logic [31:0]      wb_mem_q  [DEPTH];
  logic [31:0]      wb_mem_d  [DEPTH];
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TS_W-1:0]  ts_mem_q [DEPTH];
  logic [TS_W-1:0]  ts_mem_d [DEPTH];
`endif

  logic evt_c, pop_c, push_c, drop_c, full_c;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    full_c = (count_q == FULL_CNT);
    pop_c  = (count_q != '0) && rec_ready;
    evt_c  = cap_en && (!prev_vld_q || (NPC != prev_npc_q));
    push_c = evt_c && (!full_c || pop_c);
    drop_c = evt_c && full_c && !pop_c;
  end

  always_comb begin
    prev_npc_d = NPC;
    prev_vld_d = 1'b1;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    npc_mem_d  = npc_mem_q;
    wb_mem_d   = wb_mem_q;
`ifdef TRACE_TIMESTAMP_EN
    ts_d       = ts_q + TS_W'(1);
    ts_mem_d   = ts_mem_q;
`endif

    if (push_c) begin
      npc_mem_d[wr_ptr_q] = NPC;
      wb_mem_d[wr_ptr_q]  = WB_OUT;
`ifdef TRACE_TIMESTAMP_EN
      ts_mem_d[wr_ptr_q]  = ts_q;
`endif
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (drop_c) begin
      ovf_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // Storage is cleared on reset so the head reads 0 rather than X when empty.
  always_ff @(posedge clk) begin
    if (RN) begin
      prev_npc_q <= '0;
      prev_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
      npc_mem_q  <= '{default: '0};
      wb_mem_q   <= '{default: '0};
`ifdef TRACE_TIMESTAMP_EN
      ts_q       <= '0;
      ts_mem_q   <= '{default: '0};
`endif
    end else begin
      prev_npc_q <= prev_npc_d;
      prev_vld_q <= prev_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      npc_mem_q  <= npc_mem_d;
      wb_mem_q   <= wb_mem_d;
`ifdef TRACE_TIMESTAMP_EN
      ts_q       <= ts_d;
      ts_mem_q   <= ts_mem_d;
`endif
    end
  end

  assign rec_valid = (count_q != '0);
  assign rec_npc   = npc_mem_q[rd_ptr_q];
  assign rec_wb    = wb_mem_q[rd_ptr_q];
`ifdef TRACE_TIMESTAMP_EN
  assign rec_ts    = ts_mem_q[rd_ptr_q];
`else
  assign rec_ts    = '0;
`endif
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/iiitb_rv32i_trace_cap.md
# iiitb_rv32i_trace_cap

Writeback trace capture unit for the iiitb_rv32i core. It watches the core's NPC and WB_OUT outputs, detects each instruction retirement as a change in NPC, and pushes an {NPC, WB_OUT} record into an internal first-word-fall-through FIFO. A downstream consumer, such as a debug UART bridge or a bench checker, drains the FIFO over a valid/ready handshake. Overflow is counted, never stalls the core.

## Interface

Parameters:
- DEPTH, 16: FIFO entries; power of 2, ≥ 2.
- TS_W, 16: timestamp width in bits; used only when the timestamp feature is compiled in.

Ports:
- clk  in  1  core clock; single clock domain.
- RN  in  1  reset; synchronous, active-high. Same signal that drives the core's RN.
- NPC  in  32  core next-PC output.
- WB_OUT  in  32  core writeback value output.
- cap_en  in  1  capture enable; when low, no events are generated.
- rec_valid  out  1  FIFO head is valid.
- rec_ready  in  1  consumer accepts the head record.
- rec_npc  out  32  head record NPC.
- rec_wb  out  32  head record WB_OUT.
- rec_ts  out  TS_W  head record timestamp; constant 0 when the feature is compiled out.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky overflow flag.
- drop_cnt  out  16  dropped-record counter; saturates at 16'hFFFF.

## Operation

- Internal state:
  - prev_npc: 32-bit register, loaded with NPC every non-reset cycle.
  - prev_vld: set on the first non-reset cycle, then held.
- Event condition: cap_en && (!prev_vld || NPC != prev_npc).
  - The first sample after reset is always an event when cap_en is high.
  - While cap_en is low, prev_npc still tracks NPC, so re-enabling does not produce a spurious event.
- Push: on an event, the record {NPC, WB_OUT[, ts]} is written at the same clock edge.
- Pop: when rec_valid && rec_ready at a clock edge, the head entry is removed.
- Output signals:
  - rec_valid = (count != 0).
  - rec_* show the head entry combinationally from FIFO storage.
  - rec_* are don't-care while rec_valid is low, but must not be X after reset; they read 0 from cleared storage.
- Full FIFO:
  - Event with no pop: the record is dropped, ovf is set, and drop_cnt increments (saturating).
  - Event with a simultaneous pop: both happen, the push is accepted, and count stays at DEPTH with no drop.
- Empty FIFO with a simultaneous event and rec_ready: no pop (rec_valid is low); the push proceeds and count becomes 1.
- Pointers: read and write pointers are $clog2(DEPTH) bits, wrap modulo DEPTH, and count is tracked separately.
- Clearing: ovf and drop_cnt clear only on RN.

## Timing

- Reset: all of the following are 0 after an RN edge.
  - rec_valid, count, ovf, drop_cnt, rec_npc, rec_wb, rec_ts.
  - Pointers, prev_vld and the timestamp counter.
- Reset mid-operation: FIFO contents are discarded. A handshake in progress on that edge is not completed.
- Latency: an event sampled at edge N makes the record visible on rec_* with rec_valid high in the cycle after edge N, when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- count reflects the post-edge state, updated at the same edge as push and pop.
- rec_valid never depends combinationally on rec_ready.

## Configuration

- TRACE_TIMESTAMP_EN defined:
  - A free-running TS_W-bit cycle counter runs; it is 0 at reset, increments every cycle and wraps.
  - Each record stores the counter value at its push edge, and rec_ts presents it.
- TRACE_TIMESTAMP_EN undefined:
  - No counter and no timestamp storage.
  - rec_ts is tied to 0.
  - All other behaviour is identical.

## Test plan

- Reset, then NPC held at 0x0 with cap_en=1: exactly one record {0x0, WB_OUT}, count=1.
- NPC sequence 0x0, 0x4, 0x4, 0x8, rec_ready=0: count=3, records in order 0x0, 0x4, 0x8, ovf=0.
- DEPTH=16, rec_ready=0, 20 distinct NPC changes from an empty FIFO: count=16, ovf=1, drop_cnt=4. The head remains the first record.
- FIFO full, an event coinciding with rec_ready=1: count stays 16, drop_cnt unchanged, and the new record is last in drain order.
- cap_en low for 3 NPC changes, then high with NPC unchanged: no records. The next NPC change yields one record.
- Assert RN with 5 entries queued: the next cycle shows count=0, rec_valid=0, ovf=0, drop_cnt=0. With TRACE_TIMESTAMP_EN, the first record after release has rec_ts=0.
